// File: rtl/random_led_pkg.sv
// Shared types and constants for the random LED sequencer: FSM states and the
// 16-bit Galois LFSR definition (x^16+x^14+x^13+x^11+1).
package random_led_pkg;

    localparam int                LFSR_W            = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // One right-shift Galois step; the taps are folded in when bit 0 falls out.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/random_led_lfsr.sv
// Free-running 16-bit Galois LFSR; advances every clock and exposes its low
// OUT_W bits as the candidate pattern.
module random_led_lfsr
    import random_led_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = LFSR_SEED_DEFAULT,
    parameter int                OUT_W = LFSR_W
) (
    input  logic             clock_i,
    input  logic             reset_i,
    output logic [OUT_W-1:0] pattern_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign pattern_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/random_led_sequencer.sv
// Plays FRAMES pseudo-random LED patterns per gerar_jogada pulse, HOLD_CYCLES each.
// Build option RANDOM_LED_NO_REPEAT_EN: a candidate equal to the previous frame is inverted.
//   state | meaning
//   IDLE  | waiting for gerar_jogada; frame keeps last pattern (0 after abort/reset)
//   LOAD  | new frame presented, carrega_frame high
//   HOLD  | frame on display, hold counter running
//   DONE  | play complete, jogada_done high
module random_led_sequencer
    import random_led_pkg::*;
#(
    parameter int                WIDTH       = 8,
    parameter int                FRAMES      = 4,
    parameter int                HOLD_CYCLES = 1000,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_SEED_DEFAULT,
    localparam int               IDX_W       = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             gerar_jogada,
    input  logic             abort,
    output logic [WIDTH-1:0] frame,
    output logic [IDX_W-1:0] frame_idx,
    output logic             carrega_frame,
    output logic             busy,
    output logic             jogada_done
);

    localparam int               CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAMES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] frame_q, frame_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cand_raw, cand_nz, cand;
    logic             frame_end;

    random_led_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (WIDTH)
    ) u_lfsr (
        .clock_i   (clock),
        .reset_i   (reset),
        .pattern_o (cand_raw)
    );

    assign cand_nz = (cand_raw == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : cand_raw;

`ifdef RANDOM_LED_NO_REPEAT_EN
    // All-ones has a zero inverse, so it falls back to flipping bit 0 instead.
    always_comb begin
        cand = cand_nz;
        if (cand_nz == frame_q) begin
            cand = (&cand_nz) ? (cand_nz ^ WIDTH'(1)) : ~cand_nz;
        end
    end
`else
    assign cand = cand_nz;
`endif

    assign frame_end = (state_q == ST_LOAD) ? (HOLD_CYCLES == 1) : (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            frame_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gerar_jogada && !abort) begin
                        state_d = ST_LOAD;
                        frame_d = cand;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
                ST_LOAD, ST_HOLD: begin
                    if (!frame_end) begin
                        state_d = ST_HOLD;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                        frame_d = cand;
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = '0;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign frame         = frame_q;
    assign frame_idx     = idx_q;
    assign carrega_frame = (state_q == ST_LOAD);
    assign busy          = (state_q != ST_IDLE);
    assign jogada_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_random_led_sequencer.sv
// Scoreboard bench for random_led_sequencer: main instance with HOLD_CYCLES=5,
// second instance with HOLD_CYCLES=1 for the back-to-back and short-hold cases.
module tb_random_led_sequencer;

    localparam int W = 8;
    localparam int F = 4;
    localparam int H = 5;

    logic         clock;
    logic         reset;
    logic         gerar, abort_s, gerar2;
    logic [W-1:0] frame, frame2;
    logic [1:0]   frame_idx, frame_idx2;
    logic         carrega, carrega2, busy, busy2, done, done2;

    random_led_sequencer #(.WIDTH(W), .FRAMES(F), .HOLD_CYCLES(H)) dut (
        .clock         (clock),
        .reset         (reset),
        .gerar_jogada  (gerar),
        .abort         (abort_s),
        .frame         (frame),
        .frame_idx     (frame_idx),
        .carrega_frame (carrega),
        .busy          (busy),
        .jogada_done   (done)
    );

    random_led_sequencer #(.WIDTH(W), .FRAMES(F), .HOLD_CYCLES(1)) dut2 (
        .clock         (clock),
        .reset         (reset),
        .gerar_jogada  (gerar2),
        .abort         (1'b0),
        .frame         (frame2),
        .frame_idx     (frame_idx2),
        .carrega_frame (carrega2),
        .busy          (busy2),
        .jogada_done   (done2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [W-1:0] filt(input logic [W-1:0] raw, input logic [W-1:0] prev);
        logic [W-1:0] c;
        c = (raw == '0) ? 8'h01 : raw;
`ifdef RANDOM_LED_NO_REPEAT_EN
        if (c == prev) c = (c == 8'hFF) ? 8'hFE : ~c;
`else
        if (prev == 8'h00 && c == 8'h00) c = 8'h01;
`endif
        return c;
    endfunction

    // Reference LFSR and edge counter, reset and clocked like the DUT.
    logic [15:0] lfsr_m;
    int          cyc;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_m <= 16'hACE1;
            cyc    <= 0;
        end else begin
            lfsr_m <= step(lfsr_m);
            cyc    <= cyc + 1;
        end
    end

    typedef struct {
        logic [W-1:0] fr;
        int           idx;
        int           at;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   busy_q[$];
    logic [W-1:0] model_frame = '0;

    // Load/done monitor
    initial forever begin
        @(negedge clock);
        if (reset) begin
            if (carrega) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("frame", int'(frame), int'(e.fr));
                    chk("frame_idx", int'(frame_idx), e.idx);
                    chk("load_cycle", cyc, e.at);
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    // Busy run-length monitor
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                run = 0;
            end else if (busy) begin
                run++;
            end else if (run > 0) begin
                if (busy_q.size() == 0) chk("unexpected_busy_run", run, 0);
                else chk("busy_len", run, busy_q.pop_front());
                run = 0;
            end
        end
    end

    task automatic start_play(input int n_loads, input bit exp_done, input int busy_len);
        logic [15:0]  s;
        logic [W-1:0] prev, c;
        int           c0;
        @(negedge clock);
        s    = lfsr_m;
        c0   = cyc;
        prev = model_frame;
        for (int n = 0; n < n_loads; n++) begin
            exp_t e;
            c = filt(s[W-1:0], prev);
            e.fr  = c;
            e.idx = n;
            e.at  = c0 + 1 + n * H;
            exp_q.push_back(e);
            prev = c;
            for (int j = 0; j < H; j++) s = step(s);
        end
        model_frame = exp_done ? prev : '0;
        if (exp_done) done_q.push_back(c0 + 1 + F * H);
        if (busy_len > 0) busy_q.push_back(busy_len);
        gerar = 1'b1;
        @(negedge clock);
        gerar = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_frame"}, int'(frame), 0);
        chk({tag, "_idx"}, int'(frame_idx), 0);
        chk({tag, "_carrega"}, int'(carrega), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        logic [15:0]  s;
        logic [W-1:0] prev2, c;
        int           plays, viol_z, viol_r;

        reset   = 1'b0;
        gerar   = 1'b0;
        abort_s = 1'b0;
        gerar2  = 1'b0;
        @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Basic play: loads at k+1,k+6,k+11,k+16, done at k+21, busy 21
        start_play(F, 1'b1, F * H + 1);
        repeat (24) @(negedge clock);

        // Second gerar_jogada during HOLD is ignored
        start_play(F, 1'b1, F * H + 1);
        repeat (7) @(negedge clock);
        gerar = 1'b1;
        @(negedge clock);
        gerar = 1'b0;
        repeat (18) @(negedge clock);

        // gerar together with abort in IDLE does not start a play
        gerar   = 1'b1;
        abort_s = 1'b1;
        @(negedge clock);
        gerar   = 1'b0;
        abort_s = 1'b0;
        chk("gerar_abort_idle_busy", int'(busy), 0);
        @(negedge clock);

        // Abort sampled at edge k+7 -> IDLE with frame 0 in cycle k+8
        start_play(2, 1'b0, 7);
        repeat (6) @(negedge clock);
        abort_s = 1'b1;
        @(negedge clock);
        abort_s = 1'b0;
        chk("abort_frame", int'(frame), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_carrega", int'(carrega), 0);
        repeat (3) @(negedge clock);
        start_play(F, 1'b1, F * H + 1);
        repeat (24) @(negedge clock);

        // Asynchronous reset mid-HOLD, then identical restart timing
        start_play(2, 1'b0, 0);
        repeat (7) @(negedge clock);
        #2 reset = 1'b0;
        #1 check_outputs_zero("async_reset");
        model_frame = '0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        start_play(F, 1'b1, F * H + 1);
        repeat (24) @(negedge clock);

        // HOLD_CYCLES=1: four consecutive loads, done in the fifth cycle
        @(negedge clock);
        s     = lfsr_m;
        prev2 = '0;
        gerar2 = 1'b1;
        @(negedge clock);
        gerar2 = 1'b0;
        for (int n = 0; n < F; n++) begin
            c = filt(s[W-1:0], prev2);
            chk("h1_carrega", int'(carrega2), 1);
            chk("h1_idx", int'(frame_idx2), n);
            chk("h1_frame", int'(frame2), int'(c));
            chk("h1_done_early", int'(done2), 0);
            prev2 = c;
            s = step(s);
            @(negedge clock);
        end
        chk("h1_done", int'(done2), 1);
        chk("h1_carrega_off", int'(carrega2), 0);
        @(negedge clock);
        chk("h1_idle_busy", int'(busy2), 0);

        // 1000 back-to-back plays on the short-hold instance
        plays  = 0;
        viol_z = 0;
        viol_r = 0;
        prev2  = frame2;
        gerar2 = 1'b1;
        for (int i = 0; i < 8000 && plays < 1000; i++) begin
            @(negedge clock);
            if (carrega2) begin
                if (frame2 == '0) viol_z++;
                if (frame2 == prev2) viol_r++;
                prev2 = frame2;
            end
            if (done2) plays++;
        end
        gerar2 = 1'b0;
        chk("b2b_plays", plays, 1000);
        chk("b2b_zero_frames", viol_z, 0);
`ifdef RANDOM_LED_NO_REPEAT_EN
        chk("b2b_repeats", viol_r, 0);
`endif
        repeat (4) @(negedge clock);

        chk("pending_loads", exp_q.size(), 0);
        chk("pending_dones", done_q.size(), 0);
        chk("pending_busy", busy_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/random_led_sequencer.md
# random_led_sequencer

Parametrised successor to the single-frame random LED control unit. On one `gerar_jogada` pulse it plays a complete sequence of `FRAMES` pseudo-random LED patterns, holding each pattern for `HOLD_CYCLES` clocks. It owns the pattern generator and the frame register, and announces each new frame and the end of the play. It sits between the game-flow FSM, which issues `gerar_jogada` and `abort`, and the LED datapath, which consumes `frame` when `carrega_frame` is high.

## Interface
Parameters:
- `WIDTH`, default 8: number of LEDs; legal range 2..16.
- `FRAMES`, default 4: frames per play; minimum 1.
- `HOLD_CYCLES`, default 1000: clocks each frame is displayed, including its load cycle; minimum 1.
- `LFSR_SEED`, default 16'hACE1: LFSR value after reset; must be nonzero.

Ports (reset is asynchronous and active-low):
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low.
- `gerar_jogada` input 1: start a play; sampled only in IDLE.
- `abort` input 1: synchronous cancel of the current play.
- `frame` output WIDTH: current LED pattern.
- `frame_idx` output max(1,$clog2(FRAMES)): index of the current frame.
- `carrega_frame` output 1: high for one cycle when `frame` takes a new value.
- `busy` output 1: a play is in progress.
- `jogada_done` output 1: one-cycle pulse when a play completes normally.

## Operation
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Free-running: advances every clock in every state, so the pattern depends on when the play starts.
  - Candidate pattern = `lfsr[WIDTH-1:0]`.
- Candidate filtering:
  - Zero candidate → replaced with `{{WIDTH-1{1'b0}},1'b1}`.
  - With the no-repeat feature compiled in, see Configuration.
- FSM states and transitions:
  - IDLE: on `gerar_jogada` && !`abort` → LOAD. On this edge, `frame` ← filtered candidate, `frame_idx` ← 0, hold counter ← 0.
  - LOAD: `carrega_frame`=1. If HOLD_CYCLES==1 → next frame directly; otherwise → HOLD.
  - HOLD: hold counter increments each cycle. When the counter reaches HOLD_CYCLES-1, the state leaves HOLD.
  - Leaving LOAD or HOLD: if `frame_idx`==FRAMES-1 → DONE. Otherwise → LOAD, with `frame` ← new filtered candidate and `frame_idx`+1 on that edge.
  - DONE: `jogada_done`=1 → IDLE.
- `busy` = state is LOAD, HOLD or DONE.
- `abort` in any state other than IDLE:
  - Next state is IDLE; `frame` ← 0, `frame_idx` ← 0.
  - No `jogada_done` pulse.
  - `abort` takes priority over every other transition.
- `gerar_jogada` outside IDLE is ignored. It is not queued.
- After DONE, `frame` keeps the last pattern until the next play or an abort.
- Reset values: `frame`=0, `frame_idx`=0, `carrega_frame`=0, `busy`=0, `jogada_done`=0, state IDLE, lfsr=`LFSR_SEED`, hold counter=0.

## Timing
- `gerar_jogada` sampled high at edge k → `carrega_frame` high in cycle k+1, with the new `frame` already stable.
- Frame n load cycle is k+1+n·HOLD_CYCLES.
- `jogada_done` occurs in cycle k+1+FRAMES·HOLD_CYCLES.
- `busy` is high for FRAMES·HOLD_CYCLES+1 consecutive cycles.
- A new `gerar_jogada` is accepted in the first IDLE cycle after DONE.
- Hold counter width is max(1,$clog2(HOLD_CYCLES)). The counter clears on every entry to LOAD.
- Asserting `reset` mid-play drives all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- `RANDOM_LED_NO_REPEAT_EN` defined:
  - A zero-substituted candidate equal to the previous `frame` is replaced by its bitwise inverse.
  - If that inverse is zero, the replacement is candidate^1 instead.
  - Adjacent frames within a play therefore always differ.
  - The first frame of a play is compared against the `frame` value held in IDLE.
- Not defined: only zero substitution is applied. Adjacent frames may repeat.

## Structure
- Package `random_led_pkg` holds:
  - the state enum (IDLE, LOAD, HOLD, DONE);
  - `LFSR_W`=16;
  - the tap mask 16'hB400;
  - the default seed.
- Sub-module `random_led_lfsr`: free-running LFSR with a seed parameter and the same async active-low reset.
- The FSM, counters and filtering logic stay in the top module.

## Test plan
All scenarios use WIDTH=8, FRAMES=4, HOLD_CYCLES=5 unless stated otherwise.
- One-cycle `gerar_jogada` at edge k → `carrega_frame` in cycles k+1, k+6, k+11, k+16; `frame_idx` 0,1,2,3; `jogada_done` at k+21; `busy` high for 21 cycles.
- 1000 back-to-back plays with the macro defined → `frame` never 0, and every pair of adjacent frames differs.
- `gerar_jogada` pulsed again at k+8 → no extra frames; timeline identical to the first scenario.
- `abort` at k+7 → cycle k+8 is IDLE with `frame`=0 and `busy`=0; no `jogada_done`; a fresh play is then accepted normally.
- HOLD_CYCLES=1 → `carrega_frame` high for 4 consecutive cycles, then `jogada_done` in the 5th cycle.
- `reset` low mid-HOLD → all outputs 0 at once. After release, the same start cycle reproduces the identical frame sequence.
